// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Holds the FSM state type, the reset vector default and the PC step size.
package fetch_pkg;

    typedef enum logic {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_t;

    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC00000;
    localparam int unsigned PC_STEP              = 4;

endpackage

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, issues one outstanding imem request at a time
// and presents each fetched instruction to decode through a single registered output slot.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(RESET_VECTOR_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_addr,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ready,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             if_valid,
    output logic [WIDTH-1:0] if_pc,
    output logic [WIDTH-1:0] if_pc_plus4,
    output logic [WIDTH-1:0] if_instr
);

    fetch_state_t     state_r;
    fetch_state_t     state_s;
    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] pc_s;
    logic             drop_r;
    logic             drop_s;
    logic             if_valid_r;
    logic             if_valid_s;
    logic [WIDTH-1:0] if_pc_r;
    logic [WIDTH-1:0] if_pc_s;
    logic [WIDTH-1:0] if_pc_plus4_r;
    logic [WIDTH-1:0] if_pc_plus4_s;
    logic [WIDTH-1:0] if_instr_r;
    logic [WIDTH-1:0] if_instr_s;

    logic             req_s;
    logic             accept_s;
    logic             consume_s;
    logic [WIDTH-1:0] target_s;
    logic [WIDTH-1:0] pc_inc_s;
    logic             redirect_lsb_unused_s;

    // Redirect targets are word aligned; the low address bits are discarded.
    assign target_s              = {redirect_addr[WIDTH-1:2], 2'b00};
    assign redirect_lsb_unused_s = ^redirect_addr[1:0];
    assign pc_inc_s              = pc_r + WIDTH'(PC_STEP);

    // Request only when idle, not being redirected, and the slot will have room.
    always_comb begin
        req_s = 1'b0;
        if (state_r == REQ) begin
            req_s = !redirect_valid && (!if_valid_r || !stall);
        end else begin
            req_s = 1'b0;
        end
    end

    assign accept_s  = req_s && imem_ready;
    assign consume_s = if_valid_r && !stall;

    // Next-state logic: redirect beats response, response beats slot consumption.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        drop_s        = drop_r;
        if_valid_s    = if_valid_r;
        if_pc_s       = if_pc_r;
        if_pc_plus4_s = if_pc_plus4_r;
        if_instr_s    = if_instr_r;
        if (redirect_valid) begin
            pc_s       = target_s;
            if_valid_s = 1'b0;
            case (state_r)
                REQ: begin
                    state_s = REQ;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_s = REQ;
                        drop_s  = 1'b0;
                    end else begin
                        // The in-flight response is wrong-path; mark it for discard.
                        state_s = WAIT;
                        drop_s  = 1'b1;
                    end
                end
                default: begin
                    state_s = REQ;
                    drop_s  = 1'b0;
                end
            endcase
        end else begin
            if (consume_s) begin
                if_valid_s = 1'b0;
            end else begin
                if_valid_s = if_valid_r;
            end
            case (state_r)
                REQ: begin
                    if (accept_s) begin
                        state_s = WAIT;
                    end else begin
                        state_s = REQ;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state_s = REQ;
                        drop_s  = 1'b0;
                        if (!drop_r) begin
                            if_valid_s    = 1'b1;
                            if_pc_s       = pc_r;
                            if_pc_plus4_s = pc_inc_s;
                            if_instr_s    = imem_rdata;
                            pc_s          = pc_inc_s;
                        end else begin
                            pc_s = pc_r;
                        end
                    end else begin
                        state_s = WAIT;
                    end
                end
                default: begin
                    state_s = REQ;
                    drop_s  = 1'b0;
                end
            endcase
        end
    end

    // State, PC and output-slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= REQ;
            pc_r          <= RESET_VECTOR;
            drop_r        <= 1'b0;
            if_valid_r    <= 1'b0;
            if_pc_r       <= {WIDTH{1'b0}};
            if_pc_plus4_r <= {WIDTH{1'b0}};
            if_instr_r    <= {WIDTH{1'b0}};
        end else begin
            state_r       <= state_s;
            pc_r          <= pc_s;
            drop_r        <= drop_s;
            if_valid_r    <= if_valid_s;
            if_pc_r       <= if_pc_s;
            if_pc_plus4_r <= if_pc_plus4_s;
            if_instr_r    <= if_instr_s;
        end
    end

    assign imem_req    = req_s;
    assign imem_addr   = pc_r;
    assign if_valid    = if_valid_r;
    assign if_pc       = if_pc_r;
    assign if_pc_plus4 = if_pc_plus4_r;
    assign if_instr    = if_instr_r;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a transaction-level model (queue of outstanding fetches plus
// a one-entry slot) is compared with the DUT every cycle; directed scenarios add literal checks.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [31:0] if_instr;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_pc_plus4    (if_pc_plus4),
        .if_instr       (if_instr)
    );

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [31:0] addr;
        logic        wrong;
    } pend_t;

    // Reference model: outstanding fetches, architectural PC, decode slot.
    pend_t       pend_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_if_pc;
    logic [31:0] m_if_instr;
    bit          m_valid;
    bit          m_init = 1'b0;
    bit          exp_req;

    // Memory behaviour and stimulus knobs.
    bit          mem_busy = 1'b0;
    logic [31:0] mem_addr;
    int          mem_cnt;
    bit          ready_cmd;
    bit          spur;
    int          delay_cfg;
    bit          acc;
    logic [31:0] acc_addr;
    bit          last_rvalid;
    logic [31:0] acc_q[$];
    logic [31:0] hold_pc;
    logic [31:0] hold_instr;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h13579BDF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_update();
        pend_t p;
        bit    consume;
        if (rst) begin
            m_pc       = 32'hBFC00000;
            pend_q.delete();
            m_valid    = 1'b0;
            m_if_pc    = 32'h0;
            m_if_instr = 32'h0;
            m_init     = 1'b1;
        end else if (m_init) begin
            consume = m_valid && !stall;
            if (redirect_valid) begin
                m_pc    = {redirect_addr[31:2], 2'b00};
                m_valid = 1'b0;
                if (pend_q.size() != 0) begin
                    if (imem_rvalid) void'(pend_q.pop_front());
                    else pend_q[0].wrong = 1'b1;
                end
            end else if (pend_q.size() == 0) begin
                if (exp_req && imem_ready) pend_q.push_back('{addr: m_pc, wrong: 1'b0});
                if (consume) m_valid = 1'b0;
            end else if (imem_rvalid) begin
                p = pend_q.pop_front();
                if (!p.wrong) begin
                    m_valid    = 1'b1;
                    m_if_pc    = p.addr;
                    m_if_instr = instr_of(p.addr);
                    m_pc       = p.addr + 32'd4;
                end else if (consume) begin
                    m_valid = 1'b0;
                end
            end else if (consume) begin
                m_valid = 1'b0;
            end
        end
    endtask

    // One clock: memory drives its response, outputs are compared, then the edge is taken.
    task automatic step();
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mem_busy) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = instr_of(mem_addr);
                mem_busy    = 1'b0;
            end
        end else if (spur) begin
            imem_rvalid = 1'b1;
        end
        imem_ready  = ready_cmd && !mem_busy;
        last_rvalid = imem_rvalid;
        #1;
        exp_req = m_init && (pend_q.size() == 0) && !redirect_valid && (!m_valid || !stall);
        if (m_init) begin
            chk("imem_req", 32'(imem_req), 32'(exp_req));
            if (exp_req) chk("imem_addr", imem_addr, m_pc);
            chk("if_valid", 32'(if_valid), 32'(m_valid));
            if (m_valid) begin
                chk("if_pc", if_pc, m_if_pc);
                chk("if_pc_plus4", if_pc_plus4, m_if_pc + 32'd4);
                chk("if_instr", if_instr, m_if_instr);
            end
        end
        acc      = (imem_req === 1'b1) && (imem_ready === 1'b1);
        acc_addr = imem_addr;
        @(posedge clk);
        if (acc) begin
            acc_q.push_back(acc_addr);
            mem_busy = 1'b1;
            mem_addr = acc_addr;
            mem_cnt  = delay_cfg;
        end
        model_update();
        @(negedge clk);
    endtask

    task automatic run_until_accept(input string name, input logic [31:0] exp);
        int n;
        n = acc_q.size();
        for (int i = 0; i < 40 && acc_q.size() == n; i++) step();
        if (acc_q.size() == n) begin
            checks++;
            errors++;
            $display("FAIL %s: no request accepted within 40 cycles, expected addr %h", name, exp);
        end else begin
            chk(name, acc_q[$], exp);
        end
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        for (int i = 0; i < 40 && if_valid !== 1'b1; i++) step();
        chk(name, if_pc, exp_pc);
    endtask

    initial begin
        rst            = 1'b1;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_addr  = 32'h0;
        ready_cmd      = 1'b1;
        spur           = 1'b0;
        delay_cfg      = 1;
        imem_ready     = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        @(negedge clk);

        // Reset and sequential fetch.
        step();
        rst = 1'b0;
        acc_q.delete();
        #1;
        chk("rst_if_valid", 32'(if_valid), 32'h0);
        chk("rst_if_pc", if_pc, 32'h0);
        chk("rst_if_pc_plus4", if_pc_plus4, 32'h0);
        chk("rst_if_instr", if_instr, 32'h0);
        chk("rst_first_req", 32'(imem_req), 32'h1);
        chk("rst_first_addr", imem_addr, 32'hBFC00000);
        repeat (4) step();
        chk("seq_slot_pc", if_pc, 32'hBFC00004);
        chk("seq_slot_pc4", if_pc_plus4, 32'hBFC00008);

        // Stall hold with the slot occupied.
        stall      = 1'b1;
        hold_pc    = if_pc;
        hold_instr = if_instr;
        repeat (5) step();
        #1;
        chk("stall_no_req", 32'(imem_req), 32'h0);
        chk("stall_pc_hold", if_pc, hold_pc);
        chk("stall_instr_hold", if_instr, hold_instr);
        stall     = 1'b0;
        delay_cfg = 3;
        step();
        if (acc_q.size() >= 3) begin
            chk("seq_addr0", acc_q[0], 32'hBFC00000);
            chk("seq_addr1", acc_q[1], 32'hBFC00004);
            chk("seq_addr2", acc_q[2], 32'hBFC00008);
        end else begin
            checks++;
            errors++;
            $display("FAIL seq_count: got %0d accepted requests expected 3", acc_q.size());
        end

        // Redirect while a response is pending.
        redirect_valid = 1'b1;
        redirect_addr  = 32'h80000010;
        step();
        redirect_valid = 1'b0;
        delay_cfg      = 1;
        run_until_accept("redir_wait_addr", 32'h80000010);
        wait_valid("redir_wait_slot", 32'h80000010);

        // Redirect coinciding with the response.
        delay_cfg = 2;
        run_until_accept("post_redir_seq", 32'h80000014);
        for (int i = 0; i < 10 && !(mem_busy && mem_cnt == 1); i++) step();
        redirect_valid = 1'b1;
        redirect_addr  = 32'h80000013;
        step();
        redirect_valid = 1'b0;
        chk("redir_rvalid_seen", 32'(last_rvalid), 32'h1);
        chk("redir_rvalid_flush", 32'(if_valid), 32'h0);

        // Backpressure, then wrap through the top of the address space.
        ready_cmd = 1'b0;
        delay_cfg = 1;
        repeat (3) begin
            step();
            #1;
            chk("bp_req_held", 32'(imem_req), 32'h1);
            chk("bp_addr_held", imem_addr, 32'h80000010);
        end
        redirect_valid = 1'b1;
        redirect_addr  = 32'hFFFFFFFC;
        step();
        redirect_valid = 1'b0;
        ready_cmd      = 1'b1;
        run_until_accept("wrap_top_addr", 32'hFFFFFFFC);
        wait_valid("wrap_top_slot", 32'hFFFFFFFC);
        chk("wrap_pc4", if_pc_plus4, 32'h00000000);
        delay_cfg = 3;
        run_until_accept("wrap_addr", 32'h00000000);

        // Reset while waiting; the stale response must be ignored.
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_if_valid", 32'(if_valid), 32'h0);
        delay_cfg = 1;
        run_until_accept("midrst_restart", 32'hBFC00000);
        step();
        chk("midrst_no_stale_load", if_instr, instr_of(32'hBFC00000));

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            rst            = ($urandom_range(0, 199) == 0);
            stall          = ($urandom_range(0, 2) == 0);
            redirect_valid = ($urandom_range(0, 14) == 0);
            redirect_addr  = ($urandom_range(0, 7) == 0) ? (32'hFFFFFFFC | 32'($urandom_range(0, 3)))
                                                         : 32'($urandom);
            ready_cmd      = ($urandom_range(0, 2) != 0);
            spur           = ($urandom_range(0, 7) == 0);
            delay_cfg      = $urandom_range(1, 3);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch controller for the pipelined RISC-V core. It owns the program counter and sequences instruction-memory requests through a valid/ready request channel and a separate response channel. It presents one fetched instruction, with its PC and PC+4, to decode through a single output slot. It also handles decode stalls and redirects from execute (branch/jump), discarding wrong-path responses.

## Interface
- WIDTH, 32, address/data width
- RESET_VECTOR, 32'hBFC00000, first fetch address after reset

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- stall  in  1  decode cannot accept; output slot must hold
- redirect_valid  in  1  execute redirects fetch this cycle
- redirect_addr  in  WIDTH  redirect target; bits [1:0] forced to 0
- imem_req  out  1  request valid
- imem_addr  out  WIDTH  request address (= pc)
- imem_ready  in  1  memory accepts request this cycle
- imem_rvalid  in  1  response valid; earliest the cycle after acceptance
- imem_rdata  in  WIDTH  response instruction
- if_valid  out  1  output slot holds a valid instruction
- if_pc  out  WIDTH  PC of slot instruction
- if_pc_plus4  out  WIDTH  if_pc + 4
- if_instr  out  WIDTH  slot instruction

## Operation
- **State machine, 2 states:**
  - REQ: issue the request.
  - WAIT: one request outstanding.
  - Maximum of one outstanding request.
- **Reset values:**
  - state=REQ, pc=RESET_VECTOR, drop=0.
  - if_valid=0; if_pc, if_pc_plus4, if_instr = 0.
- **REQ:**
  - imem_req = !redirect_valid && (!if_valid || !stall), i.e. the output slot is empty or being consumed.
  - imem_req && imem_ready → WAIT.
  - imem_rvalid in REQ is ignored.
- **WAIT:**
  - imem_req=0.
  - On imem_rvalid with drop=0:
    - load if_instr=imem_rdata, if_pc=pc, if_pc_plus4=pc+4, if_valid=1;
    - pc ← pc+4;
    - → REQ.
  - On imem_rvalid with drop=1: discard the response, clear drop, → REQ.
- **Slot consumption:** if_valid && !stall clears if_valid on that edge, unless a new response loads the slot on the same edge.
- **Redirect (any state):**
  - pc ← {redirect_addr[WIDTH-1:2], 2'b00}.
  - if_valid ← 0 (flush).
  - In WAIT without rvalid: drop ← 1, stay in WAIT.
  - In WAIT with rvalid the same cycle: response discarded, → REQ.
  - In REQ: no request is issued that cycle, so no wrong-path acceptance; stay in REQ.
- **Priority:** rst > redirect > response > stall.
- **Arithmetic:** pc+4 wraps modulo 2^WIDTH (0xFFFFFFFC → 0x00000000).

## Timing
- First request: imem_req=1, imem_addr=RESET_VECTOR in the first cycle after rst deasserts.
- Fetch latency: response in cycle t → if_valid=1 in cycle t+1.
- Throughput with zero-wait memory (ready=1, rvalid one cycle after accept): one instruction every 2 cycles.
- Redirect in cycle t:
  - if_valid=0 in t+1.
  - imem_req for the target no earlier than t+1.
  - Target instruction in the slot ≥ 2 cycles after its request is accepted.
- While stalled with if_valid=1: all if_* outputs stable, no new request is issued.
- rst mid-operation: all state returns to reset values on that edge. Any response arriving later is ignored because the state is REQ.

## Structure
- Package fetch_pkg:
  - typedef enum logic {REQ, WAIT} fetch_state_t;
  - localparam RESET_VECTOR_DEFAULT = 32'hBFC00000;
  - localparam PC_STEP = 4.
- Single module; no sub-module. Next-PC mux, FSM and output slot stay inline.

## Test plan
- **Reset/sequential fetch:** rst 1 cycle, ready=1, rvalid next cycle → requests at 0xBFC00000, 0xBFC00004, 0xBFC00008; if_pc/if_pc_plus4 match; if_valid pulses every 2 cycles.
- **Stall hold:** stall=1 while if_valid=1 (pc 0xBFC00004) for 5 cycles → if_* stable, imem_req=0; stall drops → next request 0xBFC00008.
- **Redirect in WAIT:** redirect to 0x80000010 before a pending response arrives → response dropped, if_valid stays 0, next request 0x80000010, slot later shows if_pc=0x80000010.
- **Redirect with simultaneous rvalid:** redirect_addr=0x80000013 in the same cycle as rvalid → response discarded, next imem_addr=0x80000010.
- **Backpressure/wrap:** imem_ready=0 for 3 cycles → imem_req held with stable addr. Redirect to 0xFFFFFFFC → following fetch addr 0x00000000.
- **Mid-operation reset:** rst asserted in WAIT, then a stale rvalid arrives → ignored; if_valid=0; fetch restarts at 0xBFC00000.
